// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Pipeline sequencer for the 5-stage MIPS core.
//               - Detects read-after-write hazards between the instruction in
//                 ID and producers in EXE and MEM. Drives ID freeze and bubble.
//               - Flushes IF/ID and ID/EXE when a branch resolves taken.
//               - Holds every pipeline register while MEM waits on a
//                 multi-cycle data memory. A timeout sets a sticky error flag.
//               - Counts the cycles in which freeze is high. The count
//                 saturates.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: FORWARDING_EN
//   defined   : operand forwarding. Only a load-use pair stalls, and the
//               stall is one bubble. fwd_sel1/fwd_sel2 select the bypass.
//   undefined : full-stall hazard rule. fwd_sel1/fwd_sel2 are tied to 2'b00.
// ----------------------------------------------------------------------------
// Parameters
//   MEM_TIMEOUT : consecutive memory-wait cycles before mem_err sets (>=1)
//   CNT_W       : width of stall_cnt
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous active-high reset
//   id_src1      in   5      ID source register 1
//   id_src2      in   5      ID source register 2 (0 for immediate forms)
//   exe_dst      in   5      EXE-stage destination register
//   exe_wb_en    in   1      EXE-stage instruction writes back
//   exe_mem_r_en in   1      EXE-stage instruction is a load
//   mem_dst      in   5      MEM-stage destination register
//   mem_wb_en    in   1      MEM-stage instruction writes back
//   br_taken     in   1      branch resolved taken in EXE this cycle
//   mem_req      in   1      MEM stage accesses data memory this cycle
//   mem_ready    in   1      data memory completes the access this cycle
//   freeze       out  1      hold PC and the IF/ID register
//   bubble       out  1      ID emits zero control
//   flush        out  1      clear IF/ID and ID/EXE
//   hold_all     out  1      stall every pipeline register
//   fwd_sel1     out  2      operand-1 source: 00 regfile, 01 EXE/MEM, 10 MEM/WB
//   fwd_sel2     out  2      operand-2 source, same encoding
//   mem_err      out  1      sticky memory-timeout flag
//   stall_cnt    out  CNT_W  saturating count of freeze cycles
// ============================================================================
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic [4:0]       exe_dst,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [4:0]       mem_dst,
  input  logic             mem_wb_en,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze,
  output logic             bubble,
  output logic             flush,
  output logic             hold_all,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // The wait counter only has to reach MEM_TIMEOUT. It saturates there.
  localparam int                 WCNT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0]  c_WAIT_MAX  = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0]  c_WAIT_ONE  = WCNT_W'(1);
  localparam logic [CNT_W-1:0]   c_STALL_MAX = '1;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic                r_mem_err;
  logic [CNT_W-1:0]    r_stall_cnt;

  state_t              w_state_nxt;
  logic [WCNT_W-1:0]   w_wait_nxt;
  logic                w_hold_all;
  logic                w_err_set;
  logic                w_hazard;
  logic                w_freeze;
  logic [1:0]          w_fwd_sel1;
  logic [1:0]          w_fwd_sel2;

  // A producer matches a source only if it writes back and the register is
  // not $zero. Register 0 never creates a dependency.
  function automatic logic f_match(input logic [4:0] s, input logic [4:0] d,
                                   input logic w);
    return (s != 5'd0) && w && (s == d);
  endfunction

  logic w_m1_exe;
  logic w_m1_mem;
  logic w_m2_exe;
  logic w_m2_mem;

  assign w_m1_exe = f_match(id_src1, exe_dst, exe_wb_en);
  assign w_m1_mem = f_match(id_src1, mem_dst, mem_wb_en);
  assign w_m2_exe = f_match(id_src2, exe_dst, exe_wb_en);
  assign w_m2_mem = f_match(id_src2, mem_dst, mem_wb_en);

`ifdef FORWARDING_EN
  // With bypass paths, only a load in EXE cannot be forwarded in time. That
  // case costs one bubble. EXE/MEM forwarding wins over MEM/WB because it
  // carries the younger value of the register.
  always_comb begin
    w_hazard   = exe_mem_r_en && (w_m1_exe || w_m2_exe);

    w_fwd_sel1 = 2'b00;
    if (w_m1_exe && !exe_mem_r_en) begin
      w_fwd_sel1 = 2'b01;
    end else if (w_m1_mem) begin
      w_fwd_sel1 = 2'b10;
    end

    w_fwd_sel2 = 2'b00;
    if (w_m2_exe && !exe_mem_r_en) begin
      w_fwd_sel2 = 2'b01;
    end else if (w_m2_mem) begin
      w_fwd_sel2 = 2'b10;
    end
  end
`else
  // Without bypass, any pending write to a source register stalls ID until
  // the producer has left MEM. The load flag is not needed in this build.
  logic w_unused_load;
  assign w_unused_load = exe_mem_r_en;

  always_comb begin
    w_hazard   = w_m1_exe || w_m1_mem || w_m2_exe || w_m2_mem;
    w_fwd_sel1 = 2'b00;
    w_fwd_sel2 = 2'b00;
  end
`endif

  // Memory-wait sequencing. The RUN-state request cycle already counts as
  // the first wait cycle, so a timeout of N raises mem_err at the end of the
  // Nth consecutive held cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_hold_all  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          w_hold_all  = 1'b1;
          w_state_nxt = ST_MEM_WAIT;
          w_wait_nxt  = c_WAIT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = '0;
        end else begin
          w_hold_all = 1'b1;
          if (r_wait_cnt != c_WAIT_MAX) begin
            w_wait_nxt = r_wait_cnt + c_WAIT_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wait_nxt  = '0;
      end
    endcase
    w_err_set = w_hold_all && (w_wait_nxt == c_WAIT_MAX);
  end

  // Priority: a held pipe ignores the branch because EXE is frozen too. A
  // taken branch discards the wrong-path ID instruction, so stalling it would
  // be pointless.
  assign w_freeze = w_hold_all || (!br_taken && w_hazard);

  assign freeze    = w_freeze;
  assign bubble    = !w_hold_all && !br_taken && w_hazard;
  assign flush     = !w_hold_all && br_taken;
  assign hold_all  = w_hold_all;
  assign fwd_sel1  = w_fwd_sel1;
  assign fwd_sel2  = w_fwd_sel2;
  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_err_set) begin
        r_mem_err <= 1'b1;
      end
      if (w_freeze && (r_stall_cnt != c_STALL_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Directed self-checking bench for hazard_stall_ctrl. It uses
//               MEM_TIMEOUT=8 and CNT_W=4, so the stall counter saturates
//               within the run. Expected values hold for both builds, with
//               and without FORWARDING_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef FORWARDING_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_src1, id_src2, exe_dst, mem_dst;
  logic             exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic             br_taken, mem_req, mem_ready;
  logic             freeze, bubble, flush, hold_all, mem_err;
  logic [1:0]       fwd_sel1, fwd_sel2;
  logic [CNT_W-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .exe_dst      (exe_dst),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dst      (mem_dst),
    .mem_wb_en    (mem_wb_en),
    .br_taken     (br_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .freeze       (freeze),
    .bubble       (bubble),
    .flush        (flush),
    .hold_all     (hold_all),
    .fwd_sel1     (fwd_sel1),
    .fwd_sel2     (fwd_sel2),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic e_frz, input logic e_bub,
                         input logic e_fl, input logic e_hold);
    chk_val({tag, "/freeze"},   32'(freeze),   32'(e_frz));
    chk_val({tag, "/bubble"},   32'(bubble),   32'(e_bub));
    chk_val({tag, "/flush"},    32'(flush),    32'(e_fl));
    chk_val({tag, "/hold_all"}, 32'(hold_all), 32'(e_hold));
  endtask

  // Advance one clock. Update the counter model from the freeze value the
  // bench expects for the cycle that just ended.
  task automatic tick(input logic exp_frz);
    logic was_rst;
    was_rst = rst;
    @(posedge clk);
    if (was_rst) exp_cnt = 0;
    else if (exp_frz && exp_cnt < CNT_MAX) exp_cnt++;
    #1;
    chk_val("stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
  endtask

  task automatic clear_inputs();
    id_src1 = '0; id_src2 = '0; exe_dst = '0; mem_dst = '0;
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b0;
    br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
    #1;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_val("reset/mem_err", 32'(mem_err), 32'd0);
    chk_val("reset/fwd_sel1", 32'(fwd_sel1), 32'd0);
    tick(1'b0);

    // RAW on src1 from EXE (not a load)
    exe_dst = 5'd5; exe_wb_en = 1'b1; id_src1 = 5'd5;
    #1;
    chk_ctl("raw_exe_s1", !FWD, !FWD, 1'b0, 1'b0);
    chk_val("raw_exe_s1/fwd1", 32'(fwd_sel1), FWD ? 32'd1 : 32'd0);
    tick(!FWD);
    // Register 0 never creates a hazard
    id_src1 = 5'd0; exe_dst = 5'd0;
    #1;
    chk_ctl("reg0", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0);
    // RAW on src2 from MEM
    clear_inputs();
    mem_dst = 5'd9; mem_wb_en = 1'b1; id_src2 = 5'd9;
    #1;
    chk_ctl("raw_mem_s2", !FWD, !FWD, 1'b0, 1'b0);
    chk_val("raw_mem_s2/fwd2", 32'(fwd_sel2), FWD ? 32'd2 : 32'd0);
    tick(!FWD);
    mem_wb_en = 1'b0;
    #1;
    chk_ctl("mem_nowb", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0);

    // EXE producer on src2: ALU result, then load-use
    clear_inputs();
    exe_dst = 5'd7; exe_wb_en = 1'b1; id_src2 = 5'd7;
    #1;
    chk_ctl("alu_s2", !FWD, !FWD, 1'b0, 1'b0);
    chk_val("alu_s2/fwd2", 32'(fwd_sel2), FWD ? 32'd1 : 32'd0);
    tick(!FWD);
    exe_mem_r_en = 1'b1;
    #1;
    chk_ctl("load_use", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_val("load_use/fwd2", 32'(fwd_sel2), 32'd0);
    tick(1'b1);
    // EXE and MEM both write r7: EXE wins
    exe_mem_r_en = 1'b0; mem_dst = 5'd7; mem_wb_en = 1'b1;
    #1;
    chk_val("exe_wins/fwd2", 32'(fwd_sel2), FWD ? 32'd1 : 32'd0);
    chk_ctl("exe_wins", !FWD, !FWD, 1'b0, 1'b0);
    tick(!FWD);

    // Taken branch vs hazard vs hold
    clear_inputs();
    exe_dst = 5'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; id_src2 = 5'd3;
    br_taken = 1'b1;
    #1;
    chk_ctl("br_haz", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0);
    mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    chk_ctl("br_hold", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1);
    mem_ready = 1'b1;
    #1;
    chk_ctl("br_ready", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0);

    // Three wait cycles, then ready
    clear_inputs();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctl("mwait", 1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b1);
    end
    mem_ready = 1'b1;
    #1;
    chk_ctl("mready", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0);
    chk_val("mready/mem_err", 32'(mem_err), 32'd0);

    // Timeout: mem_err sets after the 8th wait cycle and stays set
    mem_ready = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      #1;
      chk_ctl("tmo_hold", 1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b1);
      chk_val($sformatf("tmo_err_c%0d", i), 32'(mem_err), (i >= MEM_TIMEOUT) ? 32'd1 : 32'd0);
    end
    mem_ready = 1'b1;
    #1;
    chk_ctl("tmo_ready", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0);
    chk_val("tmo_sticky", 32'(mem_err), 32'd1);

    // Reset while in MEM_WAIT
    mem_ready = 1'b0;
    tick(1'b1);
    mem_req = 1'b0; rst = 1'b1;
    #1;
    chk_ctl("rst_in_wait", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1);
    rst = 1'b0;
    #1;
    chk_ctl("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_val("post_rst/mem_err", 32'(mem_err), 32'd0);
    tick(1'b0);
    mem_req = 1'b1;
    #1;
    chk_ctl("re_req", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1);
    mem_ready = 1'b1;
    #1;
    chk_ctl("re_ready", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
